// File: rtl/ddr_readout_seq.sv
// ---------------------------------------------------------------------------
// ddr_readout_seq
//
// Read-side sequencer of the DDR capture/readout path. It requests DDR read
// bursts, drains the byte FIFO that each burst lands in, and reassembles the
// bytes (most significant byte first) into 32-bit capture words. It unpacks
// every word into three 10-bit ADC samples, each tagged with the word's
// overrange and trigger flags, and presents them on a valid/ready stream.
//
// Ports
//   clk_100mhz_in         DDR user clock, also the byte-FIFO read clock
//   reset_n_i             asynchronous active-low reset
//   start_i               start pulse, sampled only while idle
//   start_addr_i          byte address of first burst (low byte forced to 0)
//   num_words_i           number of capture words to emit (0 = none)
//   busy_o                transfer in progress
//   done_o                one-cycle completion pulse
//   ddr_read_req_o        one-cycle burst read request
//   ddr_read_address_o    burst byte address, stable from request to drain
//   ddr_read_done_i       burst has landed in the byte FIFO (level)
//   ddr_read_fifoen_o     byte FIFO read enable
//   ddr_read_fifoempty_i  byte FIFO empty
//   ddr_read_data_i       byte FIFO data, valid the cycle after a read
//   sample_o              unpacked 10-bit ADC sample
//   sample_or_o           ADC overrange flag (word bit 31)
//   sample_trig_o         trigger status flag (word bit 30)
//   sample_valid_o        sample valid
//   sample_ready_i        sink ready
// ---------------------------------------------------------------------------
module ddr_readout_seq #(
   parameter int BURST_BYTES = 256
) (
   input  logic        clk_100mhz_in,
   input  logic        reset_n_i,
   input  logic        start_i,
   input  logic [31:0] start_addr_i,
   input  logic [31:0] num_words_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        ddr_read_req_o,
   output logic [31:0] ddr_read_address_o,
   input  logic        ddr_read_done_i,
   output logic        ddr_read_fifoen_o,
   input  logic        ddr_read_fifoempty_i,
   input  logic [7:0]  ddr_read_data_i,
   output logic [9:0]  sample_o,
   output logic        sample_or_o,
   output logic        sample_trig_o,
   output logic        sample_valid_o,
   input  logic        sample_ready_i
);

   localparam int                CNT_W     = $clog2(BURST_BYTES);
   localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BURST_BYTES - 1);
   localparam logic [31:0]       ADDR_STEP = 32'(BURST_BYTES);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_DONE,
      DRAIN,
      FLUSH
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [31:0]       addr_q;
   logic [31:0]       words_left;
   logic [31:0]       words_left_nxt;
   logic [CNT_W-1:0]  byte_cnt;
   logic              reads_all;
   logic              rd_pend;
   logic [2:0]        asm_cnt;
   logic [31:0]       asm_word;
   logic [31:0]       new_word;
   logic [31:0]       hold_word;
   logic              hold_valid;
   logic [1:0]        samp_idx;
   logic              done_q;
   logic              done_nxt;

   logic              handshake;
   logic              last_hs;
   logic              hold_free;
   logic              discard;
   logic              word_done;
   logic              word_full;
   logic              asm_load;
   logic              asm_drop;
   logic              asm_clear;
   logic              can_accept;
   logic              fifo_rd;
   logic              burst_end;
   logic [3:0]        outstanding;

   // Assembler and hold-register handshake terms. A word completes in the
   // same cycle its fourth byte arrives so it can go straight into the hold
   // register; if the hold register is still busy the word parks in the
   // assembler (asm_cnt == 4) and reads stop until it moves on.
   always_comb begin
      handshake      = hold_valid && sample_ready_i;
      last_hs        = handshake && (samp_idx == 2'd2);
      hold_free      = !hold_valid || last_hs;
      discard        = (words_left == 32'd0);
      word_done      = rd_pend && (asm_cnt == 3'd3);
      word_full      = (asm_cnt == 3'd4);
      new_word       = word_full ? asm_word : {asm_word[23:0], ddr_read_data_i};
      asm_load       = (word_done || word_full) && !discard && hold_free;
      asm_drop       = word_done && discard;
      asm_clear      = asm_load || asm_drop;
      outstanding    = {1'b0, asm_cnt} + {3'b000, rd_pend};
      can_accept     = (outstanding < 4'd4) || asm_clear;
      fifo_rd        = (state == DRAIN) && !reads_all && !ddr_read_fifoempty_i && can_accept;
      words_left_nxt = words_left - {31'd0, asm_load};
      burst_end      = reads_all && (asm_clear || ((asm_cnt == 3'd0) && !rd_pend));
   end

   // State register.
   always_ff @(posedge clk_100mhz_in or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. The burst is only finished once its last word has
   // been loaded or dropped, so the words_left decision sees its final value.
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               if (num_words_i == 32'd0) begin
                  done_nxt = 1'b1;
               end else begin
                  state_nxt = REQ;
               end
            end
         end
         REQ: begin
            state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (ddr_read_done_i) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (burst_end) begin
               state_nxt = (words_left_nxt != 32'd0) ? REQ : FLUSH;
            end
         end
         FLUSH: begin
            if (hold_free) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Transfer bookkeeping: burst address, remaining word count and the
   // per-burst byte counter. All 256 bytes of a burst are always read, even
   // after the requested word count has been reached.
   always_ff @(posedge clk_100mhz_in or negedge reset_n_i) begin
      if (!reset_n_i) begin
         addr_q     <= 32'd0;
         words_left <= 32'd0;
         byte_cnt   <= '0;
         reads_all  <= 1'b0;
         done_q     <= 1'b0;
         rd_pend    <= 1'b0;
      end else begin
         done_q  <= done_nxt;
         rd_pend <= fifo_rd;

         if ((state == IDLE) && start_i && (num_words_i != 32'd0)) begin
            addr_q     <= start_addr_i & ~(ADDR_STEP - 32'd1);
            words_left <= num_words_i;
         end else begin
            words_left <= words_left_nxt;
            if ((state == DRAIN) && burst_end && (words_left_nxt != 32'd0)) begin
               addr_q <= addr_q + ADDR_STEP;
            end
         end

         if ((state == WAIT_DONE) && ddr_read_done_i) begin
            byte_cnt  <= '0;
            reads_all <= 1'b0;
         end else if (fifo_rd) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == LAST_BYTE) begin
               reads_all <= 1'b1;
            end
         end
      end
   end

   // Byte assembler: shifts bytes in MSB first.
   always_ff @(posedge clk_100mhz_in or negedge reset_n_i) begin
      if (!reset_n_i) begin
         asm_cnt  <= 3'd0;
         asm_word <= 32'd0;
      end else begin
         if (asm_clear) begin
            asm_cnt <= 3'd0;
         end else if (rd_pend) begin
            asm_word <= {asm_word[23:0], ddr_read_data_i};
            asm_cnt  <= asm_cnt + 3'd1;
         end
      end
   end

   // Hold register and unpacker. A new word may replace the current one in
   // the same cycle its third sample is taken, which keeps the stream at
   // three samples every four cycles with a full FIFO.
   always_ff @(posedge clk_100mhz_in or negedge reset_n_i) begin
      if (!reset_n_i) begin
         hold_word  <= 32'd0;
         hold_valid <= 1'b0;
         samp_idx   <= 2'd0;
      end else begin
         if (asm_load) begin
            hold_word  <= new_word;
            hold_valid <= 1'b1;
            samp_idx   <= 2'd0;
         end else if (handshake) begin
            if (samp_idx == 2'd2) begin
               hold_valid <= 1'b0;
               samp_idx   <= 2'd0;
            end else begin
               samp_idx <= samp_idx + 2'd1;
            end
         end
      end
   end

   // Sample select: low field first, then middle, then high.
   always_comb begin
      sample_o = hold_word[9:0];
      case (samp_idx)
         2'd1:    sample_o = hold_word[19:10];
         2'd2:    sample_o = hold_word[29:20];
         default: sample_o = hold_word[9:0];
      endcase
   end

   assign sample_or_o        = hold_word[31];
   assign sample_trig_o      = hold_word[30];
   assign sample_valid_o     = hold_valid;
   assign busy_o             = (state != IDLE);
   assign done_o             = done_q;
   assign ddr_read_req_o     = (state == REQ);
   assign ddr_read_address_o = addr_q;
   assign ddr_read_fifoen_o  = fifo_rd;

endmodule

// File: tb/tb_ddr_readout_seq.sv
// ---------------------------------------------------------------------------
// tb_ddr_readout_seq
//
// Bench for ddr_readout_seq. A DDR/byte-FIFO model answers each read request
// with 64 words (MSB byte first) and pushes the samples those words must
// produce onto a scoreboard queue; samples are popped and compared as the
// DUT hands them over.
// ---------------------------------------------------------------------------
module tb_ddr_readout_seq;

   logic        clk_100mhz_in = 1'b0;
   logic        reset_n_i;
   logic        start_i;
   logic [31:0] start_addr_i;
   logic [31:0] num_words_i;
   logic        busy_o;
   logic        done_o;
   logic        ddr_read_req_o;
   logic [31:0] ddr_read_address_o;
   logic        ddr_read_done_i;
   logic        ddr_read_fifoen_o;
   logic        ddr_read_fifoempty_i;
   logic [7:0]  ddr_read_data_i;
   logic [9:0]  sample_o;
   logic        sample_or_o;
   logic        sample_trig_o;
   logic        sample_valid_o;
   logic        sample_ready_i;

   ddr_readout_seq dut (
      .clk_100mhz_in        (clk_100mhz_in),
      .reset_n_i            (reset_n_i),
      .start_i              (start_i),
      .start_addr_i         (start_addr_i),
      .num_words_i          (num_words_i),
      .busy_o               (busy_o),
      .done_o               (done_o),
      .ddr_read_req_o       (ddr_read_req_o),
      .ddr_read_address_o   (ddr_read_address_o),
      .ddr_read_done_i      (ddr_read_done_i),
      .ddr_read_fifoen_o    (ddr_read_fifoen_o),
      .ddr_read_fifoempty_i (ddr_read_fifoempty_i),
      .ddr_read_data_i      (ddr_read_data_i),
      .sample_o             (sample_o),
      .sample_or_o          (sample_or_o),
      .sample_trig_o        (sample_trig_o),
      .sample_valid_o       (sample_valid_o),
      .sample_ready_i       (sample_ready_i)
   );

   always #5 clk_100mhz_in = ~clk_100mhz_in;

   int          compared   = 0;
   int          mismatched = 0;

   logic [7:0]  byte_q[$];
   logic [11:0] exp_q[$];
   logic [31:0] exp_addr_q[$];

   int          req_count;
   int          samples_seen;
   int          bytes_read;
   int          done_count;
   int          cyc = 0;
   int          last_hs_cyc;
   int          done_cyc;
   int          gen_mode;
   logic [31:0] cur_num_words;
   logic [31:0] word_base;
   bit          rand_ready = 1'b0;
   bit          rand_empty = 1'b0;
   bit          model_flush = 1'b0;
   bit          burst_pending = 1'b0;
   int          burst_delay = 0;
   int          done_left = 0;
   bit          data_due = 1'b0;
   logic [7:0]  pend_byte;
   bit          prev_stall = 1'b0;
   logic [11:0] prev_sample;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Loads one burst into the byte FIFO and records the samples it must yield.
   task automatic pushBurst();
      logic [31:0] idx;
      logic [31:0] w;
      for (int i = 0; i < 64; i++) begin
         idx = word_base + 32'(i);
         case (gen_mode)
            1:       w = (idx == 32'd0) ? 32'hC00F_FC01 : idx;
            2:       w = $urandom;
            default: w = idx;
         endcase
         for (int b = 3; b >= 0; b--) byte_q.push_back(w[b*8 +: 8]);
         if (idx < cur_num_words) begin
            exp_q.push_back({w[31], w[30], w[9:0]});
            exp_q.push_back({w[31], w[30], w[19:10]});
            exp_q.push_back({w[31], w[30], w[29:20]});
         end
      end
      word_base = word_base + 32'd64;
   endtask

   // DDR + byte FIFO + sink model: observe on the falling edge, drive just
   // after the rising edge.
   initial begin
      ddr_read_done_i      = 1'b0;
      ddr_read_fifoempty_i = 1'b1;
      ddr_read_data_i      = 8'h00;
      sample_ready_i       = 1'b1;
      forever begin
         @(negedge clk_100mhz_in);
         cyc++;
         if (reset_n_i) begin
            if (ddr_read_req_o) begin
               req_count++;
               if (exp_addr_q.size() > 0)
                  checkOutput("req_addr", ddr_read_address_o, exp_addr_q.pop_front());
               burst_pending = 1'b1;
               burst_delay   = $urandom_range(2, 5);
            end
            if (ddr_read_fifoen_o) begin
               checkOutput("fifoen_while_empty", 32'(ddr_read_fifoempty_i), 32'd0);
               bytes_read++;
               pend_byte = (byte_q.size() > 0) ? byte_q.pop_front() : 8'hEE;
               data_due  = 1'b1;
            end
            if (prev_stall)
               checkOutput("stall_hold",
                           {19'd0, sample_valid_o, sample_or_o, sample_trig_o, sample_o},
                           {19'd0, 1'b1, prev_sample});
            if (sample_valid_o && sample_ready_i) begin
               samples_seen++;
               last_hs_cyc = cyc;
               if (exp_q.size() > 0)
                  checkOutput("sample", {20'd0, sample_or_o, sample_trig_o, sample_o},
                              {20'd0, exp_q.pop_front()});
            end
            prev_stall  = sample_valid_o && !sample_ready_i;
            prev_sample = {sample_or_o, sample_trig_o, sample_o};
            if (done_o) begin
               done_count++;
               done_cyc = cyc;
            end
         end else begin
            prev_stall = 1'b0;
         end

         @(posedge clk_100mhz_in);
         #1;
         if (model_flush) begin
            byte_q.delete();
            burst_pending   = 1'b0;
            data_due        = 1'b0;
            done_left       = 0;
            ddr_read_done_i = 1'b0;
            model_flush     = 1'b0;
         end else begin
            if (data_due) begin
               ddr_read_data_i = pend_byte;
               data_due        = 1'b0;
            end
            if (done_left > 0) begin
               done_left--;
               if (done_left == 0) ddr_read_done_i = 1'b0;
            end
            if (burst_pending) begin
               if (burst_delay == 0) begin
                  pushBurst();
                  ddr_read_done_i = 1'b1;
                  done_left       = 2;
                  burst_pending   = 1'b0;
               end else begin
                  burst_delay--;
               end
            end
         end
         sample_ready_i       = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         ddr_read_fifoempty_i = (byte_q.size() == 0) ||
                                (rand_empty && ($urandom_range(0, 2) == 0));
      end
   end

   task automatic clearScoreboard();
      exp_q.delete();
      exp_addr_q.delete();
      req_count    = 0;
      samples_seen = 0;
      bytes_read   = 0;
      done_count   = 0;
      last_hs_cyc  = 0;
      done_cyc     = 0;
      word_base    = 32'd0;
   endtask

   // Pulses start for one cycle and samples the following two cycles.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] num,
                                output logic c1_busy, output logic c1_req,
                                output logic c1_done, output logic c2_req);
      @(posedge clk_100mhz_in);
      #1;
      start_addr_i = addr;
      num_words_i  = num;
      start_i      = 1'b1;
      @(posedge clk_100mhz_in);
      #1;
      start_i = 1'b0;
      @(negedge clk_100mhz_in);
      c1_busy = busy_o;
      c1_req  = ddr_read_req_o;
      c1_done = done_o;
      @(negedge clk_100mhz_in);
      c2_req = ddr_read_req_o;
   endtask

   task automatic runTransfer(input logic [31:0] addr, input logic [31:0] num, input int mode,
                              input bit rr, input bit re, input bit mid_start,
                              input bit chk_latency);
      logic b1, r1, d1, r2;
      int   bursts;
      int   waited;
      clearScoreboard();
      gen_mode      = mode;
      cur_num_words = num;
      rand_ready    = rr;
      rand_empty    = re;
      bursts        = int'((num + 32'd63) / 32'd64);
      for (int i = 0; i < bursts; i++)
         exp_addr_q.push_back((addr & 32'hFFFF_FF00) + 32'(i) * 32'd256);
      applyStimulus(addr, num, b1, r1, d1, r2);
      checkOutput("busy_cycle1", 32'(b1), 32'd1);
      checkOutput("req_cycle1", 32'(r1), 32'd1);
      checkOutput("req_cycle2", 32'(r2), 32'd0);
      if (mid_start) begin
         repeat (20) @(negedge clk_100mhz_in);
         @(posedge clk_100mhz_in);
         #1;
         start_addr_i = 32'hABCD_0000;
         num_words_i  = 32'd999;
         start_i      = 1'b1;
         @(posedge clk_100mhz_in);
         #1;
         start_i = 1'b0;
      end
      waited = 0;
      while (done_count == 0 && waited < 20000) begin
         @(negedge clk_100mhz_in);
         waited++;
      end
      repeat (8) @(negedge clk_100mhz_in);
      checkOutput("done_count", 32'(done_count), 32'd1);
      checkOutput("busy_after_done", 32'(busy_o), 32'd0);
      checkOutput("req_count", 32'(req_count), 32'(bursts));
      checkOutput("bytes_read", 32'(bytes_read), 32'(bursts * 256));
      checkOutput("samples_seen", 32'(samples_seen), 3 * num);
      checkOutput("samples_left", 32'(exp_q.size()), 32'd0);
      if (chk_latency)
         checkOutput("done_after_last_sample", 32'(done_cyc - last_hs_cyc), 32'd1);
      rand_ready = 1'b0;
      rand_empty = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_busy"},   32'(busy_o), 32'd0);
      checkOutput({tag, "_done"},   32'(done_o), 32'd0);
      checkOutput({tag, "_req"},    32'(ddr_read_req_o), 32'd0);
      checkOutput({tag, "_fifoen"}, 32'(ddr_read_fifoen_o), 32'd0);
      checkOutput({tag, "_valid"},  32'(sample_valid_o), 32'd0);
      checkOutput({tag, "_addr"},   ddr_read_address_o, 32'd0);
      checkOutput({tag, "_sample"}, {20'd0, sample_or_o, sample_trig_o, sample_o}, 32'd0);
   endtask

   initial begin
      logic b1, r1, d1, r2;
      int   waited;
      reset_n_i    = 1'b0;
      start_i      = 1'b0;
      start_addr_i = 32'd0;
      num_words_i  = 32'd0;
      clearScoreboard();
      repeat (3) @(negedge clk_100mhz_in);
      checkResetValues("reset");
      @(posedge clk_100mhz_in);
      #1;
      reset_n_i = 1'b1;

      $display("[TB] single burst");
      runTransfer(32'h0000_0100, 32'd64, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      $display("[TB] partial last burst");
      runTransfer(32'h0000_03F7, 32'd65, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("[TB] flags and order");
      runTransfer(32'h1234_5678, 32'd1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
      $display("[TB] backpressure and empty gaps");
      runTransfer(32'h0000_1000, 32'd130, 2, 1'b1, 1'b1, 1'b0, 1'b0);

      $display("[TB] zero length");
      clearScoreboard();
      applyStimulus(32'h0000_4000, 32'd0, b1, r1, d1, r2);
      checkOutput("zero_done_cycle1", 32'(d1), 32'd1);
      checkOutput("zero_req_cycle1", 32'(r1), 32'd0);
      repeat (10) @(negedge clk_100mhz_in);
      checkOutput("zero_req_count", 32'(req_count), 32'd0);
      checkOutput("zero_done_count", 32'(done_count), 32'd1);

      $display("[TB] start while busy");
      runTransfer(32'h0000_0800, 32'd10, 0, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("[TB] reset mid drain");
      clearScoreboard();
      gen_mode      = 0;
      cur_num_words = 32'd64;
      exp_addr_q.push_back(32'h0000_2000);
      applyStimulus(32'h0000_2000, 32'd64, b1, r1, d1, r2);
      waited = 0;
      while (bytes_read < 100 && waited < 2000) begin
         @(negedge clk_100mhz_in);
         waited++;
      end
      checkOutput("reached_byte_100", 32'(bytes_read >= 100), 32'd1);
      #2;
      reset_n_i = 1'b0;
      #1;
      checkResetValues("async_reset");
      model_flush = 1'b1;
      repeat (3) @(negedge clk_100mhz_in);
      checkResetValues("held_reset");
      clearScoreboard();
      @(posedge clk_100mhz_in);
      #2;
      reset_n_i = 1'b1;
      runTransfer(32'h0000_0500, 32'd8, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
